// File: rtl/sparsity_mask_apply.sv
// Applies per-beat sparsity masks to a 16-lane result stream, forwards the masked
// beats and integrates the surviving lanes over a programmed window of beats.

module sparsity_mask_lane (
  input  logic        keep,
  input  logic [15:0] din,
  output logic [15:0] dout
);
  assign dout = keep ? din : 16'h0000;
endmodule

module sparsity_mask_apply #(
  parameter int CYCLE_SAMPLE_NUM = 16,
  parameter int DATA_WIDTH       = 256,
  parameter int MASK_FIFO_DEPTH  = 32,
  parameter int ACC_WIDTH        = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        state_changed,
  input  logic                        integration_start,
  input  logic [15:0]                 integration_length,
  input  logic [CYCLE_SAMPLE_NUM-1:0] sparsity_tdata,
  input  logic                        sparsity_tvalid,
  input  logic [DATA_WIDTH-1:0]       result_tdata,
  input  logic                        result_tvalid,
  output logic [DATA_WIDTH-1:0]       masked_tdata,
  output logic                        masked_tvalid,
  output logic [ACC_WIDTH-1:0]        integrated_tdata,
  output logic                        integrated_tvalid,
  output logic [19:0]                 sparse_count,
  output logic                        mask_overrun,
  output logic                        mask_underrun
);
  localparam int AW = $clog2(MASK_FIFO_DEPTH);
  localparam int ZW = $clog2(CYCLE_SAMPLE_NUM) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // ---------------- mask FIFO ----------------
  logic [CYCLE_SAMPLE_NUM-1:0] mem_q [MASK_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic          fifo_empty, fifo_full, beat, pop, push;
  logic [CYCLE_SAMPLE_NUM-1:0] cur_mask;

  assign beat       = result_tvalid;
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == (AW+1)'(MASK_FIFO_DEPTH));
  assign pop        = beat && !fifo_empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push       = sparsity_tvalid && (!fifo_full || pop);
  assign cur_mask   = fifo_empty ? '1 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    fcnt_d   = fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    if (state_changed) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fcnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sparsity_tdata;
  end

  // ---------------- per-lane masking ----------------
  logic [CYCLE_SAMPLE_NUM-1:0][15:0] res_lanes, msk_lanes;
  assign res_lanes = result_tdata;

  sparsity_mask_lane u_lane [CYCLE_SAMPLE_NUM-1:0] (
    .keep (cur_mask),
    .din  (res_lanes),
    .dout (msk_lanes)
  );

  logic [19:0]   lane_sum;
  logic [ZW-1:0] zcnt;

  always_comb begin
    lane_sum = '0;
    zcnt     = '0;
    for (int i = 0; i < CYCLE_SAMPLE_NUM; i++) begin
      lane_sum = lane_sum + {{4{msk_lanes[i][15]}}, msk_lanes[i]};
      zcnt     = zcnt + ZW'(!cur_mask[i]);
    end
  end

  // ---------------- stage 1 / output regs ----------------
  logic [DATA_WIDTH-1:0] masked_q, masked_d;
  logic                  mvld_q, mvld_d;
  logic [19:0]           s1_sum_q, s1_sum_d;
  logic [ZW-1:0]         s1_zc_q, s1_zc_d;
  logic                  s1_win_q, s1_win_d;
  logic                  ovr_q, ovr_d, udr_q, udr_d;

  logic [1:0]            state_q, state_d;
  logic [15:0]           len_q, len_d, bcnt_q, bcnt_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_next, acc_sat;
  logic [ACC_WIDTH:0]    acc_wide;
  logic [19:0]           scnt_q, scnt_d, scnt_next;
  logic [ACC_WIDTH-1:0]  int_q, int_d;
  logic                  ivld_q, ivld_d;
  logic [19:0]           sc_q, sc_d;

  always_comb begin
    masked_d = beat ? DATA_WIDTH'(msk_lanes) : '0;
    mvld_d   = beat;
    s1_sum_d = lane_sum;
    s1_zc_d  = zcnt;
    // Tag beats that belong to the open window; a flush drops the tag.
    s1_win_d = beat && (state_q == ST_ACCUM) && !state_changed;
    ovr_d    = ovr_q | (sparsity_tvalid && fifo_full && !beat);
    udr_d    = udr_q | (beat && fifo_empty);
  end

  // ---------------- stage 2: saturating accumulate ----------------
  assign acc_wide = {acc_q[ACC_WIDTH-1], acc_q} +
                    {{(ACC_WIDTH-19){s1_sum_q[19]}}, s1_sum_q};

  always_comb begin
    acc_sat = acc_wide[ACC_WIDTH-1:0];
    if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1])
      acc_sat = acc_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  assign acc_next  = s1_win_q ? acc_sat : acc_q;
  assign scnt_next = s1_win_q ? scnt_q + 20'(s1_zc_q) : scnt_q;

  // ---------------- window FSM ----------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    acc_d   = acc_next;
    scnt_d  = scnt_next;
    int_d   = int_q;
    sc_d    = sc_q;
    ivld_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (integration_start) begin
          len_d   = (integration_length == 16'd0) ? 16'd1 : integration_length;
          acc_d   = '0;
          scnt_d  = '0;
          bcnt_d  = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          bcnt_d = bcnt_q + 16'd1;
          if ({1'b0, bcnt_q} + 17'd1 == {1'b0, len_q}) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Last beat's stage-2 update lands this cycle, so publish the bypassed value.
        int_d   = acc_next;
        sc_d    = scnt_next;
        ivld_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_changed) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      scnt_d  = '0;
      bcnt_d  = '0;
      int_d   = int_q;
      sc_d    = sc_q;
      ivld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      masked_q <= '0;
      mvld_q   <= 1'b0;
      s1_sum_q <= '0;
      s1_zc_q  <= '0;
      s1_win_q <= 1'b0;
      ovr_q    <= 1'b0;
      udr_q    <= 1'b0;
      state_q  <= ST_IDLE;
      len_q    <= 16'd1;
      bcnt_q   <= '0;
      acc_q    <= '0;
      scnt_q   <= '0;
      int_q    <= '0;
      ivld_q   <= 1'b0;
      sc_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      masked_q <= masked_d;
      mvld_q   <= mvld_d;
      s1_sum_q <= s1_sum_d;
      s1_zc_q  <= s1_zc_d;
      s1_win_q <= s1_win_d;
      ovr_q    <= ovr_d;
      udr_q    <= udr_d;
      state_q  <= state_d;
      len_q    <= len_d;
      bcnt_q   <= bcnt_d;
      acc_q    <= acc_d;
      scnt_q   <= scnt_d;
      int_q    <= int_d;
      ivld_q   <= ivld_d;
      sc_q     <= sc_d;
    end
  end

  assign masked_tdata      = masked_q;
  assign masked_tvalid     = mvld_q;
  assign integrated_tdata  = int_q;
  assign integrated_tvalid = ivld_q;
  assign sparse_count      = sc_q;
  assign mask_overrun      = ovr_q;
  assign mask_underrun     = udr_q;

endmodule

// File: tb/tb_sparsity_mask_apply.sv
// Randomized self-checking bench; two DUTs (32- and 20-bit accumulators) share stimulus.

module tb_sparsity_mask_apply;
  localparam int N  = 16;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          state_changed, integration_start;
  logic [15:0]   integration_length;
  logic [N-1:0]  sparsity_tdata;
  logic          sparsity_tvalid;
  logic [DW-1:0] result_tdata;
  logic          result_tvalid;

  logic [DW-1:0] masked_tdata;
  logic          masked_tvalid, integrated_tvalid, mask_overrun, mask_underrun;
  logic [31:0]   integrated_tdata;
  logic [19:0]   sparse_count;

  logic [DW-1:0] m20_data;
  logic          m20_vld, i20_vld, o20, u20;
  logic [19:0]   i20_data, sc20;

  always #5 clk = ~clk;

  sparsity_mask_apply #(.ACC_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .state_changed(state_changed),
    .integration_start(integration_start), .integration_length(integration_length),
    .sparsity_tdata(sparsity_tdata), .sparsity_tvalid(sparsity_tvalid),
    .result_tdata(result_tdata), .result_tvalid(result_tvalid),
    .masked_tdata(masked_tdata), .masked_tvalid(masked_tvalid),
    .integrated_tdata(integrated_tdata), .integrated_tvalid(integrated_tvalid),
    .sparse_count(sparse_count), .mask_overrun(mask_overrun), .mask_underrun(mask_underrun)
  );

  sparsity_mask_apply #(.ACC_WIDTH(20)) u_dut20 (
    .clk(clk), .rst(rst), .state_changed(state_changed),
    .integration_start(integration_start), .integration_length(integration_length),
    .sparsity_tdata(sparsity_tdata), .sparsity_tvalid(sparsity_tvalid),
    .result_tdata(result_tdata), .result_tvalid(result_tvalid),
    .masked_tdata(m20_data), .masked_tvalid(m20_vld),
    .integrated_tdata(i20_data), .integrated_tvalid(i20_vld),
    .sparse_count(sc20), .mask_overrun(o20), .mask_underrun(u20)
  );

  int checks = 0;
  int errors = 0;

  // reference model: mask queue of bounded depth plus sticky flags
  logic [15:0] mq[$];
  bit          m_under, m_over;

  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [15:0] v);
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*16 +: 16] = v;
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    state_changed = 0; integration_start = 0; integration_length = 0;
    sparsity_tdata = 0; sparsity_tvalid = 0; result_tdata = 0; result_tvalid = 0;
    mq.delete(); m_under = 0; m_over = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One cycle of stimulus; returns the model's masked beat, lane sum and zero-mask count.
  task automatic step(input bit push, input logic [15:0] m, input bit bt,
                      input logic [DW-1:0] d, output logic [DW-1:0] exp_d,
                      output longint exp_sum, output int exp_zc);
    logic [15:0] use_m;
    sparsity_tvalid = push; sparsity_tdata = m;
    result_tvalid = bt; result_tdata = d;
    use_m = 16'hFFFF;
    if (bt) begin
      if (mq.size() > 0) use_m = mq.pop_front();
      else m_under = 1;
    end
    if (push) begin
      if (mq.size() < 32) mq.push_back(m);
      else m_over = 1;
    end
    exp_d = '0; exp_sum = 0; exp_zc = 0;
    if (bt)
      for (int i = 0; i < N; i++) begin
        if (use_m[i]) begin
          exp_d[i*16 +: 16] = d[i*16 +: 16];
          exp_sum += longint'($signed(d[i*16 +: 16]));
        end else exp_zc++;
      end
    @(posedge clk); #1;
    sparsity_tvalid = 0; result_tvalid = 0;
  endtask

  task automatic pulse_start(input logic [15:0] len);
    integration_start = 1; integration_length = len;
    @(posedge clk); #1;
    integration_start = 0;
  endtask

  // Called one cycle after the last beat; lat = 1 means the pulse was already present.
  task automatic wait_result(input int budget, output int lat, output logic [31:0] d32,
                             output logic [19:0] d20, output logic [19:0] sc);
    lat = 0; d32 = 'x; d20 = 'x; sc = 'x;
    for (int c = 1; c <= budget; c++) begin
      if (integrated_tvalid) begin
        lat = c; d32 = integrated_tdata; d20 = i20_data; sc = sparse_count;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    checks++;
    if ({masked_tdata, masked_tvalid, integrated_tdata, integrated_tvalid, sparse_count,
         mask_overrun, mask_underrun} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    checks++;
    if ({m20_data, m20_vld, i20_data, i20_vld, sc20, o20, u20} !== '0) begin
      errors++; $display("FAIL reset_outputs20: got nonzero outputs, required all 0");
    end
    do_reset();
  endtask

  task automatic test_basic_masks();
    logic [DW-1:0] ed; longint es; int ez; int lat;
    logic [31:0] d32; logic [19:0] d20, sc;
    logic [15:0] masks [3];
    int nz_exp [3];
    longint acc = 0; int zc = 0;
    masks[0] = 16'hFFFF; masks[1] = 16'h00FF; masks[2] = 16'h0000;
    nz_exp[0] = 16; nz_exp[1] = 8; nz_exp[2] = 0;
    do_reset();
    for (int k = 0; k < 3; k++) step(1, masks[k], 0, '0, ed, es, ez);
    pulse_start(16'd3);
    for (int k = 0; k < 3; k++) begin
      int nz = 0;
      integration_start = (k == 1); integration_length = 16'd1;
      step(0, '0, 1, fill(16'h0001), ed, es, ez);
      integration_start = 0;
      acc = sat(acc + es, 32); zc += ez;
      for (int i = 0; i < N; i++) if (masked_tdata[i*16 +: 16] != 0) nz++;
      checks++;
      if (nz != nz_exp[k] || masked_tdata !== ed || masked_tvalid !== 1'b1) begin
        errors++; $display("FAIL basic_beat%0d: got %0d lanes vld=%0b, required %0d lanes",
                           k, nz, masked_tvalid, nz_exp[k]);
      end
    end
    wait_result(5, lat, d32, d20, sc);
    checks++;
    if (lat != 2 || d32 !== 32'(acc) || d32 !== 32'd24) begin
      errors++; $display("FAIL basic_sum: got %0d lat %0d, required 24 lat 2", $signed(d32), lat);
    end
    checks++;
    if (sc !== 20'(zc) || sc !== 20'd24) begin
      errors++; $display("FAIL basic_sparse: got %0d, required 24", sc);
    end
    @(posedge clk); #1;
    checks++;
    if (integrated_tvalid !== 1'b0 || masked_tvalid !== 1'b0) begin
      errors++; $display("FAIL basic_pulse_width: got ivld=%0b mvld=%0b, required 0 0",
                         integrated_tvalid, masked_tvalid);
    end
  endtask

  task automatic test_underrun();
    logic [DW-1:0] ed; longint es; int ez; int lat;
    logic [31:0] d32; logic [19:0] d20, sc;
    do_reset();
    pulse_start(16'd2);
    for (int k = 0; k < 2; k++) step(0, '0, 1, fill(16'hFFFF), ed, es, ez);
    checks++;
    if (mask_underrun !== m_under || mask_underrun !== 1'b1) begin
      errors++; $display("FAIL underrun_flag: got %0b, required 1", mask_underrun);
    end
    wait_result(5, lat, d32, d20, sc);
    checks++;
    if (lat != 2 || d32 !== 32'hFFFF_FFE0 || sc !== 20'd0) begin
      errors++; $display("FAIL underrun_sum: got %0d sc %0d lat %0d, required -32 sc 0 lat 2",
                         $signed(d32), sc, lat);
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] ed; longint es; int ez;
    logic [15:0] m;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      m = 16'($urandom); step(1, m, 0, '0, ed, es, ez);
    end
    checks++;
    if (mask_overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_early: got %0b, required 0", mask_overrun);
    end
    step(1, 16'h0000, 0, '0, ed, es, ez);
    checks++;
    if (mask_overrun !== m_over || mask_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: got %0b, required 1", mask_overrun);
    end
    for (int k = 0; k < 33; k++) begin
      logic [DW-1:0] d;
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      step(0, '0, 1, d, ed, es, ez);
      checks++;
      if (masked_tdata !== ed || masked_tvalid !== 1'b1) begin
        errors++; $display("FAIL overrun_beat%0d: got %h, required %h", k, masked_tdata, ed);
      end
    end
    checks++;
    if (mask_underrun !== 1'b1) begin
      errors++; $display("FAIL overrun_underrun: got %0b, required 1", mask_underrun);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] ed; longint es; int ez; int lat;
    logic [31:0] d32; logic [19:0] d20, sc;
    longint a32, a20;
    do_reset();
    a32 = 0; a20 = 0;
    pulse_start(16'd4);
    for (int k = 0; k < 4; k++) begin
      step(0, '0, 1, fill(16'h7FFF), ed, es, ez);
      a32 = sat(a32 + es, 32); a20 = sat(a20 + es, 20);
    end
    wait_result(5, lat, d32, d20, sc);
    checks++;
    if (lat != 2 || d20 !== 20'(a20) || d20 !== 20'd524287) begin
      errors++; $display("FAIL sat20_pos: got %0d, required 524287", $signed(d20));
    end
    checks++;
    if (d32 !== 32'(a32)) begin
      errors++; $display("FAIL sat32_nosat: got %0d, required %0d", $signed(d32), a32);
    end
    @(posedge clk); #1;
    a20 = 0;
    pulse_start(16'd5);
    for (int k = 0; k < 5; k++) begin
      step(0, '0, 1, fill(k == 4 ? 16'hFFFF : 16'h7FFF), ed, es, ez);
      a20 = sat(a20 + es, 20);
    end
    wait_result(5, lat, d32, d20, sc);
    checks++;
    if (lat != 2 || d20 !== 20'(a20) || d20 !== 20'd524271) begin
      errors++; $display("FAIL sat20_recover: got %0d, required 524271", $signed(d20));
    end
  endtask

  task automatic test_state_changed();
    logic [DW-1:0] ed; longint es; int ez; int lat;
    logic [31:0] d32; logic [19:0] d20, sc;
    bit seen = 0;
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 16'h0000, 0, '0, ed, es, ez);
    pulse_start(16'd5);
    for (int k = 0; k < 2; k++) step(0, '0, 1, fill(16'h0005), ed, es, ez);
    state_changed = 1; integration_start = 1; integration_length = 16'd1;
    @(posedge clk); #1;
    state_changed = 0; integration_start = 0;
    mq.delete();
    for (int c = 0; c < 6; c++) begin
      if (integrated_tvalid) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || integrated_tdata !== 32'd0) begin
      errors++; $display("FAIL abort_no_pulse: got pulse=%0b data=%0d, required 0 0",
                         seen, integrated_tdata);
    end
    pulse_start(16'd1);
    step(0, '0, 1, fill(16'h0002), ed, es, ez);
    checks++;
    if (masked_tdata !== fill(16'h0002)) begin
      errors++; $display("FAIL abort_fifo_empty: got %h, required all lanes 2", masked_tdata);
    end
    wait_result(5, lat, d32, d20, sc);
    checks++;
    if (lat != 2 || d32 !== 32'd32 || sc !== 20'd0) begin
      errors++; $display("FAIL abort_restart: got %0d sc %0d lat %0d, required 32 sc 0 lat 2",
                         $signed(d32), sc, lat);
    end
  endtask

  task automatic test_zero_len_and_async_reset();
    logic [DW-1:0] ed; longint es; int ez; int lat;
    logic [31:0] d32; logic [19:0] d20, sc;
    do_reset();
    pulse_start(16'd0);
    step(0, '0, 1, fill(16'h0003), ed, es, ez);
    wait_result(5, lat, d32, d20, sc);
    checks++;
    if (lat != 2 || d32 !== 32'd48) begin
      errors++; $display("FAIL zero_len: got %0d lat %0d, required 48 lat 2", $signed(d32), lat);
    end
    @(posedge clk); #1;
    pulse_start(16'd4);
    step(0, '0, 1, fill(16'h0003), ed, es, ez);
    rst = 1'b1; #1;
    checks++;
    if ({masked_tdata, masked_tvalid, integrated_tdata, integrated_tvalid, sparse_count,
         mask_overrun, mask_underrun} !== '0) begin
      errors++; $display("FAIL async_reset: got mvld=%0b idata=%0d uflag=%0b, required all 0",
                         masked_tvalid, integrated_tdata, mask_underrun);
    end
    do_reset();
  endtask

  task automatic test_random_windows();
    logic [DW-1:0] ed; longint es; int ez; int lat;
    logic [31:0] d32; logic [19:0] d20, sc;
    do_reset();
    for (int w = 0; w < 8; w++) begin
      int len = $urandom_range(1, 6);
      int nb = 0; longint acc = 0; int zc = 0;
      pulse_start(16'(len));
      while (nb < len) begin
        bit bt = ($urandom % 4) != 0;
        bit ps = ($urandom % 3) != 0;
        logic [15:0] m = 16'($urandom);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        step(ps, m, bt, d, ed, es, ez);
        checks++;
        if (masked_tdata !== ed || masked_tvalid !== bt) begin
          errors++; $display("FAIL rand_masked w%0d: got %h, required %h", w, masked_tdata, ed);
        end
        if (bt) begin nb++; acc = sat(acc + es, 32); zc += ez; end
      end
      wait_result(5, lat, d32, d20, sc);
      checks++;
      if (lat != 2 || d32 !== 32'(acc) || sc !== 20'(zc)) begin
        errors++; $display("FAIL rand_window w%0d: got %0d sc %0d lat %0d, required %0d sc %0d lat 2",
                           w, $signed(d32), sc, lat, acc, zc);
      end
      checks++;
      if (mask_overrun !== m_over || mask_underrun !== m_under) begin
        errors++; $display("FAIL rand_flags w%0d: got o=%0b u=%0b, required o=%0b u=%0b",
                           w, mask_overrun, mask_underrun, m_over, m_under);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    state_changed = 0; integration_start = 0; integration_length = 0;
    sparsity_tdata = 0; sparsity_tvalid = 0; result_tdata = 0; result_tvalid = 0;
    test_reset();
    test_basic_masks();
    test_underrun();
    test_overrun();
    test_saturation();
    test_state_changed();
    test_zero_len_and_async_reset();
    test_random_windows();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sparsity_mask_apply.md
Name: sparsity_mask_apply

Overview:
Consumer end of the sparsity path. Takes per-cycle sparsity masks from the sparsity detector (1 = lane not sparse) and the 16-lane photonic result stream, zeroes sparse lanes, and integrates the surviving lanes over a programmed window. It sits between the ADC result stream and the layer output logic. It emits a masked pass-through stream, one saturated integrated sum per window, and the window's sparse-lane count.

Parameters:
CYCLE_SAMPLE_NUM, 16, lanes per cycle; each lane is 16-bit signed.
DATA_WIDTH, 256, result bus width; equals CYCLE_SAMPLE_NUM*16.
MASK_FIFO_DEPTH, 32, mask buffer entries; must be a power of 2.
ACC_WIDTH, 32, integrated sum width, signed.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
state_changed  input  1  layer/state change; flushes FIFO, aborts window
integration_start  input  1  single-cycle pulse that arms a window
integration_length  input  16  beats per window; sampled at integration_start
sparsity_tdata  input  CYCLE_SAMPLE_NUM  mask, bit i covers lane i
sparsity_tvalid  input  1  mask valid; pushes the FIFO
result_tdata  input  DATA_WIDTH  lane i = bits [i*16+:16]
result_tvalid  input  1  result beat valid
masked_tdata  output  DATA_WIDTH  result with sparse lanes forced to 0
masked_tvalid  output  1  masked beat valid
integrated_tdata  output  ACC_WIDTH  saturated window sum
integrated_tvalid  output  1  one-cycle pulse per window
sparse_count  output  20  sparse lanes counted in the last window
mask_overrun  output  1  sticky: a mask was pushed while the FIFO was full
mask_underrun  output  1  sticky: a beat arrived while the FIFO was empty

Behaviour:
- Reset (async assert): every output 0; FIFO empty; state IDLE; accumulator, sparse counter and beat counter 0.
- Mask FIFO:
  - A push occurs on sparsity_tvalid.
  - A pop occurs on every result_tvalid beat, in any state, so masks stay aligned with beats.
  - Push and pop in the same cycle are both legal, including when the FIFO is full or empty.
  - Full with no simultaneous pop: the new mask is dropped and mask_overrun is set.
  - Empty on a beat: the mask defaults to all ones and mask_underrun is set. A mask pushed in the same cycle is not used for that beat.
- Masking: lane i is output as 0 when mask bit i is 0, otherwise it passes unchanged. For a beat in cycle T, masked_tdata/masked_tvalid appear in cycle T+1. masked_tvalid is 0 in cycles without a beat.
- Pipeline stage 1, registered at T+1: signed 20-bit sum of the masked lanes, plus the popcount of zero mask bits.
- States:
  - IDLE: when integration_start is high, latch len = max(integration_length, 1), clear the accumulator, sparse counter and beat counter, then go to ACCUM.
  - ACCUM: each beat increments the beat counter. One cycle later, stage 2 adds the stage-1 sum into the accumulator with sign-extension, saturating to the signed ACC_WIDTH range, and adds the popcount into sparse_count_acc. The beat where the counter reaches len is the last beat; go to FLUSH.
  - FLUSH: wait one cycle, then update integrated_tdata (saturated final sum including the last beat) and sparse_count, pulse integrated_tvalid, and go to IDLE.
- Latency: if the last beat is in cycle T, integrated_tvalid is high in cycle T+2.
- integration_start while in ACCUM or FLUSH: ignored.
- Beats while in IDLE: masked and passed through, not integrated.
- state_changed (synchronous, highest priority after rst):
  - Empties the FIFO, returns to IDLE, and clears the accumulators.
  - An in-flight window produces no integrated_tvalid.
  - Sticky flags and the last integrated_tdata/sparse_count are kept.
  - Wins over a simultaneous integration_start.
- Saturation: once saturated, the accumulator stays clamped; later opposite-sign beats continue from the clamped value.

Test Plan:
1. Push masks 16'hFFFF, 16'h00FF, 16'h0000. Then send 3 beats, all lanes = 16'h0001, after integration_start with length 3. Expected: masked beats carry 16, 8 and 0 non-zero lanes. integrated_tdata = 24 and sparse_count = 24, with integrated_tvalid high 2 cycles after beat 3.
2. Send 2 beats with an empty FIFO, all lanes = 16'hFFFF (-1), length 2. Expected: mask_underrun = 1, integrated_tdata = -32, sparse_count = 0.
3. Push 33 masks with no beats. Expected: mask_overrun = 1, FIFO holds the first 32, and the 33rd mask is never applied.
4. ACC_WIDTH = 20, lanes = 16'h7FFF with all-ones masks, length 4. Expected: integrated_tdata = 524287 (saturated positive).
5. integration_start with length 5; state_changed after beat 2. Expected: no integrated_tvalid, and the FIFO is empty afterwards. A new start with length 1 and one all-ones beat of 16'h0002 gives integrated_tdata = 32.
6. integration_length = 0. Expected: the window is treated as 1 beat. Assert rst mid-window: all outputs are 0 immediately, asynchronously.
